// File: rtl/seq_detect_ctrl.sv
// Masked serial pattern detector: arms on start, reports each window hit,
// and completes after a configurable number of hits.
module seq_detect_ctrl #(
    parameter int WIDTH = 9,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_pattern,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic [CNTW-1:0]  cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             a,
    output logic             match,
    output logic             done,
    output logic             busy,
    output logic [CNTW-1:0]  match_cnt
);
    localparam int FW = $clog2(WIDTH + 1);

    typedef enum logic {S_IDLE, S_ARMED} state_t;
    state_t r_state, w_state_nxt;

    logic [WIDTH-1:0] r_pat, r_mask, r_hist;
    logic [CNTW-1:0]  r_tgt, r_cnt;
    logic [FW-1:0]    r_fill;
    logic             r_match, r_done;

    logic             w_cfg_hs, w_arm, w_shift, w_full, w_hit, w_reach;
    logic [WIDTH-1:0] w_window;
    logic [CNTW-1:0]  w_cnt_inc;

    assign w_cfg_hs = cfg_valid && (r_state == S_IDLE);
    assign w_shift  = (r_state == S_ARMED) && !abort;
    assign w_window = {r_hist[WIDTH-2:0], a};
    // Fill holds WIDTH-1 once the window is primed; the current bit completes it.
    assign w_full   = (r_fill == FW'(WIDTH - 1));
    assign w_hit    = w_shift && w_full && (((w_window ^ r_pat) & r_mask) == '0);
    assign w_cnt_inc = ((r_tgt == '0) && (&r_cnt)) ? r_cnt : r_cnt + CNTW'(1);
    assign w_reach  = (r_tgt != '0) && (w_cnt_inc == r_tgt);

    always_comb begin
        w_state_nxt = r_state;
        w_arm       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort && !cfg_valid) begin
                    w_state_nxt = S_ARMED;
                    w_arm       = 1'b1;
                end
            end
            S_ARMED: begin
                if (abort || (w_hit && w_reach))
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_mask  <= '0;
            r_tgt   <= '0;
            r_hist  <= '0;
            r_fill  <= '0;
            r_cnt   <= '0;
            r_match <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_match <= w_hit;
            r_done  <= w_hit && w_reach;
            if (w_cfg_hs) begin
                r_pat  <= cfg_pattern;
                r_mask <= cfg_mask;
                r_tgt  <= cfg_target;
            end
            if (w_arm) begin
                r_hist <= '0;
                r_fill <= '0;
                r_cnt  <= '0;
            end else if (w_shift) begin
                r_hist <= w_window;
                if (!w_full)
                    r_fill <= r_fill + FW'(1);
                if (w_hit)
                    r_cnt <= w_cnt_inc;
            end
        end
    end

    assign cfg_ready = (r_state == S_IDLE);
    assign busy      = (r_state == S_ARMED);
    assign match     = r_match;
    assign done      = r_done;
    assign match_cnt = r_cnt;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Randomized + directed bench for seq_detect_ctrl; a queue-based reference
// model predicts outputs and a monitor compares them each cycle.
module tb_seq_detect_ctrl;
    localparam int WIDTH = 9;
    localparam int CNTW  = 4;

    logic             clk = 1'b0;
    logic             rst, cfg_valid, cfg_ready, start, abort, a;
    logic [WIDTH-1:0] cfg_pattern, cfg_mask;
    logic [CNTW-1:0]  cfg_target, match_cnt;
    logic             match, done, busy;

    seq_detect_ctrl #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_target(cfg_target),
        .start(start), .abort(abort), .a(a), .match(match), .done(done),
        .busy(busy), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            m, d, b, r;
        logic [CNTW-1:0] c;
    } exp_t;

    exp_t expq[$];
    int   tests = 0, fails = 0, cyc = 0;

    // Reference model state
    bit              m_armed;
    bit              m_samp[$];
    int              m_cnt;
    logic [WIDTH-1:0] m_pat, m_mask;
    int              m_tgt;

    task automatic model_step(input bit r, cv, input logic [WIDTH-1:0] p, mk,
                              input int tg, input bit st, ab, bt);
        exp_t e;
        bit   hit, dn;
        hit = 0; dn = 0;
        if (r) begin
            m_armed = 0; m_samp.delete(); m_cnt = 0;
            m_pat = '0; m_mask = '0; m_tgt = 0;
        end else if (!m_armed) begin
            if (cv) begin
                m_pat = p; m_mask = mk; m_tgt = tg;
            end else if (st && !ab) begin
                m_armed = 1; m_samp.delete(); m_cnt = 0;
            end
        end else if (ab) begin
            m_armed = 0;
        end else begin
            m_samp.push_back(bt);
            if (m_samp.size() > WIDTH) void'(m_samp.pop_front());
            if (m_samp.size() == WIDTH) begin
                hit = 1;
                for (int i = 0; i < WIDTH; i++)
                    if (m_mask[i] && (m_samp[WIDTH-1-i] != m_pat[i])) hit = 0;
            end
            if (hit) begin
                m_cnt = m_cnt + 1;
                if (m_cnt > (1 << CNTW) - 1) m_cnt = (1 << CNTW) - 1;
                if (m_tgt != 0 && m_cnt == m_tgt) begin
                    dn = 1; m_armed = 0;
                end
            end
        end
        e.m = hit; e.d = dn; e.b = m_armed; e.r = !m_armed; e.c = m_cnt[CNTW-1:0];
        expq.push_back(e);
    endtask

    task automatic step(input bit r, cv, input logic [WIDTH-1:0] p, mk,
                        input int tg, input bit st, ab, bt);
        rst = r; cfg_valid = cv; cfg_pattern = p; cfg_mask = mk;
        cfg_target = tg[CNTW-1:0]; start = st; abort = ab; a = bt;
        @(posedge clk);
        model_step(r, cv, p, mk, tg, st, ab, bt);
        cyc++;
        #1;
    endtask

    task automatic idle_cyc();
        step(0, 0, '0, '0, 0, 0, 0, 0);
    endtask

    task automatic feed(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(0, 0, '0, '0, 0, 0, 0, bits[i]);
    endtask

    always @(negedge clk) begin
        exp_t e, g;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            g = {match, done, busy, cfg_ready, match_cnt};
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL outputs cyc%0d got m=%b d=%b busy=%b rdy=%b cnt=%0d exp m=%b d=%b busy=%b rdy=%b cnt=%0d",
                         cyc, g.m, g.d, g.b, g.r, g.c, e.m, e.d, e.b, e.r, e.c);
            end
        end
    end

    initial begin
        logic [31:0] pat9;
        step(1, 0, '0, '0, 0, 0, 0, 0);
        step(1, 1, 9'h1ff, 9'h1ff, 3, 1, 0, 1);
        idle_cyc();
        // Two-hit target with partial mask
        step(0, 1, 9'b011000110, 9'b111000111, 2, 0, 0, 0);
        step(0, 0, '0, '0, 0, 1, 0, 0);
        feed(32'b011101110, 9);
        feed(32'b011101110110, 12);
        feed(32'b011000110, 9);
        idle_cyc(); idle_cyc();
        // Unlimited target, mask zero: saturation
        step(0, 1, 9'h0a5, 9'h000, 0, 0, 0, 0);
        step(0, 0, '0, '0, 0, 1, 0, 0);
        for (int i = 0; i < 30; i++) step(0, 0, '0, '0, 0, 0, 0, 1'($urandom));
        step(0, 0, '0, '0, 0, 0, 1, 0);
        idle_cyc();
        // Abort on the completing edge
        step(0, 1, 9'b101100111, 9'h1ff, 1, 0, 0, 0);
        step(0, 0, '0, '0, 0, 1, 0, 0);
        pat9 = 32'b101100111;
        feed(pat9 >> 1, 8);
        step(0, 0, '0, '0, 0, 0, 1, pat9[0]);
        idle_cyc(); idle_cyc();
        // cfg+start same cycle, then cfg while armed, then start+abort in idle
        step(0, 1, 9'b111111111, 9'h1ff, 1, 1, 0, 0);
        idle_cyc();
        step(0, 0, '0, '0, 0, 1, 0, 0);
        step(0, 1, 9'b000000000, 9'h1ff, 2, 0, 0, 1);
        feed(32'h0, 9);
        feed(32'h1ff, 9);
        step(0, 0, '0, '0, 0, 1, 1, 0);
        idle_cyc();
        // Reset mid-armed
        step(0, 0, '0, '0, 0, 1, 0, 0);
        feed(32'h1f, 5);
        step(1, 0, '0, '0, 0, 0, 0, 1);
        step(0, 1, 9'h1ff, 9'h1ff, 1, 0, 0, 0);
        step(0, 0, '0, '0, 0, 1, 0, 0);
        feed(32'h1ff, 10);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [WIDTH-1:0] rp, rm;
            rp = WIDTH'($urandom);
            rm = WIDTH'($urandom & $urandom & $urandom);
            step(($urandom % 300) == 0, ($urandom % 8) == 0, rp, rm,
                 $urandom_range(0, 3), ($urandom % 6) == 0,
                 ($urandom % 40) == 0, 1'($urandom));
        end
        idle_cyc();
        @(negedge clk); #1;
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending exp 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
